// File: rtl/secure_router_fifo.sv
// secure_router_fifo
//   Routes input words to one of NCH per-channel first-word-fall-through
//   FIFOs selected by in_addr. Each stored word carries an even-parity bit
//   as its MSB. Channels can be locked through a configuration mask; words
//   sent to a locked channel are accepted and discarded, and a saturating
//   8-bit counter records how many were dropped.
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_addr, in_data     : destination channel and payload
//   cfg_we, cfg_lock     : lock mask load strobe and mask (bit i locks ch i)
//   out_valid/out_ready  : per-channel output handshake
//   out_data             : channel i word at [i*(DATA_W+1) +: DATA_W+1]
//   drop_cnt             : saturating count of words dropped at locked channels
module secure_router_fifo #(
  parameter int DATA_W = 4,
  parameter int NCH    = 4,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      cfg_we,
  input  logic [NCH-1:0]            cfg_lock,
  output logic [NCH-1:0]            out_valid,
  input  logic [NCH-1:0]            out_ready,
  output logic [NCH*(DATA_W+1)-1:0] out_data,
  output logic [7:0]                drop_cnt
);

  localparam int WORD_W = DATA_W + 1;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  // Even parity over the payload: XOR of all payload bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic                run_r;   // high once reset release has been synchronised
  logic [NCH-1:0]      lock_r;
  logic [7:0]          drop_cnt_r;
  logic [PTR_W-1:0]    wr_ptr_r [NCH];
  logic [PTR_W-1:0]    rd_ptr_r [NCH];
  logic [WORD_W-1:0]   mem_r    [NCH][DEPTH];
  logic [WORD_W-1:0]   head_r   [NCH];

  logic [NCH-1:0]      full_s;
  logic [NCH-1:0]      empty_s;
  logic [NCH-1:0]      push_s;
  logic [NCH-1:0]      pop_s;
  logic                drop_s;
  logic [WORD_W-1:0]   in_word_s;
  logic [PTR_W-1:0]    rd_nxt_s   [NCH];
  logic [PTR_W-1:0]    wr_nxt_s   [NCH];
  logic [WORD_W-1:0]   head_nxt_s [NCH];

  // Per-channel full/empty from the extra-MSB pointer scheme.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    for (int i = 0; i < NCH; i++) begin
      empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]  = (wr_ptr_r[i][PTR_W-1] != rd_ptr_r[i][PTR_W-1]) &&
                   (wr_ptr_r[i][IDX_W-1:0] == rd_ptr_r[i][IDX_W-1:0]);
    end
  end

  // Input acceptance, push/pop/drop decisions. Transfers are suppressed
  // until run_r shows the reset release has been seen by a clock edge.
  always_comb begin
    in_word_s = {even_parity(in_data), in_data};
    in_ready  = lock_r[in_addr] | ~full_s[in_addr];
    drop_s    = run_r & in_valid & lock_r[in_addr];
    push_s    = '0;
    pop_s     = '0;
    for (int i = 0; i < NCH; i++) begin
      push_s[i] = run_r & in_valid & (in_addr == ADDR_W'(i)) & ~lock_r[i] & ~full_s[i];
      pop_s[i]  = ~empty_s[i] & out_ready[i];
    end
  end

  // Next head word: the word that will sit at the read pointer after this
  // edge. When that slot is being written this same edge, take the
  // incoming word; when the FIFO ends up empty, keep the old head.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rd_nxt_s[i] = rd_ptr_r[i] + PTR_W'(pop_s[i]);
      wr_nxt_s[i] = wr_ptr_r[i] + PTR_W'(push_s[i]);
      if (rd_nxt_s[i] == wr_nxt_s[i]) begin
        head_nxt_s[i] = head_r[i];
      end else if (push_s[i] && (rd_nxt_s[i] == wr_ptr_r[i])) begin
        head_nxt_s[i] = in_word_s;
      end else begin
        head_nxt_s[i] = mem_r[i][rd_nxt_s[i][IDX_W-1:0]];
      end
    end
  end

  // Reset-release synchroniser, lock mask and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      lock_r     <= '0;
      drop_cnt_r <= 8'd0;
    end else begin
      run_r <= 1'b1;
      if (cfg_we) begin
        lock_r <= cfg_lock;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  // Per-channel FIFO storage, pointers and registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        head_r[i]   <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_r[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i][IDX_W-1:0]] <= in_word_s;
        end
        wr_ptr_r[i] <= wr_nxt_s[i];
        rd_ptr_r[i] <= rd_nxt_s[i];
        head_r[i]   <= head_nxt_s[i];
      end
    end
  end

  // Output flattening.
  always_comb begin
    out_valid = ~empty_s;
    drop_cnt  = drop_cnt_r;
    out_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      out_data[i*WORD_W +: WORD_W] = head_r[i];
    end
  end

endmodule

// File: tb/tb_secure_router_fifo.sv
module tb_secure_router_fifo;

  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_addr;
  logic [3:0]  in_data;
  logic        cfg_we;
  logic [3:0]  cfg_lock;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [19:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in_valid8;
  logic        in_ready8;
  logic [2:0]  in_addr8;
  logic [5:0]  in_data8;
  logic        cfg_we8;
  logic [7:0]  cfg_lock8;
  logic [7:0]  out_valid8;
  logic [7:0]  out_ready8;
  logic [55:0] out_data8;
  logic [7:0]  drop_cnt8;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [4:0] q [NCH][$];
  logic [3:0] lock_m;
  int         drop_m;

  always #5 clk = ~clk;

  secure_router_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .cfg_we(cfg_we), .cfg_lock(cfg_lock),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  secure_router_fifo #(.DATA_W(6), .NCH(8), .DEPTH(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_addr(in_addr8), .in_data(in_data8), .cfg_we(cfg_we8), .cfg_lock(cfg_lock8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .drop_cnt(drop_cnt8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = 2'd0; in_data = 4'd0;
    cfg_we = 1'b0; cfg_lock = 4'd0; out_ready = 4'd0;
    in_valid8 = 1'b0; in_addr8 = 3'd0; in_data8 = 6'd0;
    cfg_we8 = 1'b0; cfg_lock8 = 8'd0; out_ready8 = 8'd0;
    #2;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
    end
    vectors++;
    if (drop_cnt !== 8'd0) begin
      miscompares++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_addr = 2'd2; in_data = 4'b1110;
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0100) begin
      miscompares++; $display("FAIL basic_out_valid got %b want 0100", out_valid);
    end
    vectors++;
    if (out_data[2*5 +: 5] !== 5'b11110) begin
      miscompares++; $display("FAIL basic_data got %b want 11110", out_data[2*5 +: 5]);
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL basic_drained got %b want 0000", out_valid);
    end
  endtask

  task automatic test_fill();
    logic [4:0] exp_w [4];
    exp_w[0] = 5'b10001; exp_w[1] = 5'b10010; exp_w[2] = 5'b00011; exp_w[3] = 5'b10100;
    out_ready = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_addr = 2'd1; in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0; in_addr = 2'd1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL fill_full_ready got %b want 0", in_ready);
    end
    in_addr = 2'd0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL fill_other_ready got %b want 1", in_ready);
    end
    out_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (out_valid[1] !== 1'b1 || out_data[1*5 +: 5] !== exp_w[k]) begin
        miscompares++;
        $display("FAIL fill_drain[%0d] got v=%b d=%b want v=1 d=%b", k, out_valid[1], out_data[1*5 +: 5], exp_w[k]);
      end
      tick();
    end
    out_ready = 4'b0000;
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL fill_empty got %b want 0000", out_valid);
    end
  endtask

  task automatic test_lock();
    cfg_we = 1'b1; cfg_lock = 4'b1000;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b1; in_addr = 2'd3;
    for (int k = 0; k < 3; k++) begin
      in_data = 4'($urandom_range(0, 15));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL lock_ready[%0d] got %b want 1", k, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid[3] !== 1'b0 || drop_cnt !== 8'd3) begin
      miscompares++; $display("FAIL lock_drop3 got v=%b cnt=%0d want v=0 cnt=3", out_valid[3], drop_cnt);
    end
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (drop_cnt !== 8'd255) begin
      miscompares++; $display("FAIL lock_saturate got %0d want 255", drop_cnt);
    end
    cfg_we = 1'b1; cfg_lock = 4'b0000;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] w [12];
    for (int k = 0; k < 12; k++) w[k] = 4'($urandom_range(0, 15));
    out_ready = 4'b0000; in_addr = 2'd0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = w[k];
      tick();
    end
    out_ready = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = w[k+2];
      #1;
      vectors++;
      if (out_valid[0] !== 1'b1 || in_ready !== 1'b1 || out_data[4:0] !== {^w[k], w[k]}) begin
        miscompares++;
        $display("FAIL wrap[%0d] got v=%b r=%b d=%b want v=1 r=1 d=%b", k, out_valid[0], in_ready, out_data[4:0], {^w[k], w[k]});
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      #1;
      vectors++;
      if (out_valid[0] !== 1'b1 || out_data[4:0] !== {^w[k], w[k]}) begin
        miscompares++;
        $display("FAIL wrap_tail[%0d] got v=%b d=%b want v=1 d=%b", k, out_valid[0], out_data[4:0], {^w[k], w[k]});
      end
      tick();
    end
    out_ready = 4'b0000;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0) begin
      miscompares++; $display("FAIL wrap_empty got %b want 0", out_valid[0]);
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    logic do_push;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 4'b0000;
    tick();
    tick();
    for (int c = 0; c < NCH; c++) q[c].delete();
    lock_m = 4'b0000;
    drop_m = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_lock  = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = lock_m[in_addr] || (q[in_addr].size() < DEP);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++; $display("FAIL rand_ready[%0d] got %b want %b", n, in_ready, exp_rdy);
      end
      for (int c = 0; c < NCH; c++) begin
        vectors++;
        if (out_valid[c] !== (q[c].size() > 0)) begin
          miscompares++; $display("FAIL rand_valid[%0d] ch%0d got %b want %b", n, c, out_valid[c], q[c].size() > 0);
        end else if (q[c].size() > 0 && out_data[c*5 +: 5] !== q[c][0]) begin
          miscompares++; $display("FAIL rand_data[%0d] ch%0d got %b want %b", n, c, out_data[c*5 +: 5], q[c][0]);
        end
      end
      vectors++;
      if (drop_cnt !== 8'(drop_m)) begin
        miscompares++; $display("FAIL rand_drop[%0d] got %0d want %0d", n, drop_cnt, drop_m);
      end
      do_push = in_valid && !lock_m[in_addr] && (q[in_addr].size() < DEP);
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (out_ready[c] && q[c].size() > 0) void'(q[c].pop_front());
      end
      if (do_push) q[in_addr].push_back({^in_data, in_data});
      if (in_valid && lock_m[in_addr] && drop_m < 255) drop_m++;
      if (cfg_we) lock_m = cfg_lock;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    cfg_we = 1'b1; cfg_lock = 4'b1000;
    tick();
    cfg_we = 1'b0;
    out_ready = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    cfg_we = 1'b1; cfg_lock = 4'b1000;
    tick();
    cfg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_addr = 2'd0; in_data = 4'(k + 5);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_addr = 2'd3; in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b1 || drop_cnt !== 8'd5) begin
      miscompares++; $display("FAIL rmid_setup got v=%b cnt=%0d want v=1 cnt=5", out_valid[0], drop_cnt);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || drop_cnt !== 8'd0) begin
      miscompares++; $display("FAIL rmid_async got v=%b cnt=%0d want v=0000 cnt=0", out_valid, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_addr = 2'd3; in_data = 4'b0101;
    tick();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL rmid_sync_first_edge got %b want 0000", out_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b1000 || drop_cnt !== 8'd0 || out_data[15 +: 5] !== 5'b00101) begin
      miscompares++;
      $display("FAIL rmid_unlocked got v=%b cnt=%0d d=%b want v=1000 cnt=0 d=00101", out_valid, drop_cnt, out_data[15 +: 5]);
    end
  endtask

  task automatic test_param();
    in_valid8 = 1'b1; in_addr8 = 3'd7; in_data8 = 6'b000111; out_ready8 = 8'd0;
    tick();
    vectors++;
    if (out_valid8 !== 8'h80 || out_data8[7*7 +: 7] !== 7'b1000111) begin
      miscompares++;
      $display("FAIL param_push got v=%h d=%b want v=80 d=1000111", out_valid8, out_data8[7*7 +: 7]);
    end
    tick();
    #1;
    vectors++;
    if (in_ready8 !== 1'b0) begin
      miscompares++; $display("FAIL param_full got %b want 0", in_ready8);
    end
    in_addr8 = 3'd6;
    #1;
    vectors++;
    if (in_ready8 !== 1'b1) begin
      miscompares++; $display("FAIL param_other got %b want 1", in_ready8);
    end
    in_valid8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_lock();
    test_wrap();
    test_random();
    test_reset_mid();
    test_param();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secure_router_fifo.md
SECURE_ROUTER_FIFO -- requirements
Module: secure_router_fifo

Interface
REQ-001 Parameter DATA_W, default 4, payload width in bits (>=1).
REQ-002 Parameter NCH, default 4, output channel count (power of two, 2..16); ADDR_W = log2(NCH), derived locally.
REQ-003 Parameter DEPTH, default 4, per-channel FIFO depth in words (power of two, 2..16).
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  router accepts input word this cycle.
REQ-008 in_addr  input  ADDR_W  destination channel index.
REQ-009 in_data  input  DATA_W  payload.
REQ-010 cfg_we  input  1  load lock mask this cycle.
REQ-011 cfg_lock  input  NCH  lock mask; bit i=1 blocks channel i.
REQ-012 out_valid  output  NCH  bit i: channel i head word valid.
REQ-013 out_ready  input  NCH  bit i: consumer of channel i takes head word.
REQ-014 out_data  output  NCH*(DATA_W+1)  channel i word at bits [i*(DATA_W+1) +: DATA_W+1].
REQ-015 drop_cnt  output  8  count of words dropped due to locked channels.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer on channel i where out_valid[i]=1 and out_ready[i]=1.
REQ-017 Lock register SHALL load cfg_lock on a rising edge with cfg_we=1; new mask applies to input transfers from the following edge.
REQ-018 in_ready SHALL be combinational: 1 if channel in_addr is locked, else 1 iff FIFO[in_addr] not full; in_ready SHALL NOT depend on in_valid or out_ready (no full-FIFO bypass).
REQ-019 Transfer to an unlocked channel SHALL push {^in_data, in_data} (even-parity bit as MSB) into FIFO[in_addr].
REQ-020 Transfer to a locked channel SHALL discard the word and increment drop_cnt; drop_cnt saturates at 255.
REQ-021 Each FIFO SHALL be first-word-fall-through: a word pushed at edge k SHALL appear on out_data with out_valid[i]=1 immediately after edge k (latency 1 cycle).
REQ-022 out_valid[i] SHALL equal FIFO[i] non-empty; out_data of an empty channel SHALL be held at its last value and is don't-care.
REQ-023 Simultaneous push and pop on the same non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-024 Push to an empty FIFO with out_ready[i]=1 SHALL NOT pop that same edge; word is popped no earlier than the next edge.
REQ-025 Read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-026 Channels SHALL be independent: a full or stalled channel SHALL NOT block transfers to other channels.
REQ-027 Locking a channel SHALL NOT flush it; words already queued SHALL still drain.
REQ-028 out_ready[i] while out_valid[i]=0 SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, empty all FIFOs (out_valid=0), clear pointers, set lock mask to 0 and drop_cnt to 0.
REQ-030 During reset in_ready SHALL be 1 (all channels empty and unlocked) and no transfer SHALL be recorded.
REQ-031 Reset asserted mid-stream SHALL discard queued words; first transfer after release SHALL land in an empty FIFO.
REQ-032 Reset release SHALL be synchronised so the first transfer occurs no earlier than the second rising edge after deassertion.

Verification
REQ-033 Defaults, no locks: in_addr=2, in_data=4'b1110 -> next cycle out_valid=4'b0100, channel 2 out_data=5'b11110; all other channels silent.
REQ-034 Fill: 4 words 1,2,3,4 to channel 1 with out_ready=0 -> in_ready=0 for in_addr=1 while in_ready=1 for in_addr=0; drain yields 5'b10001,5'b10010,5'b00011,5'b10100 in order.
REQ-035 Lock: cfg_we pulse with cfg_lock=4'b1000, then 3 words to channel 3 -> in_ready=1, out_valid[3]=0, drop_cnt=3; 300 drops -> drop_cnt=255.
REQ-036 Wrap: 10 push/pop pairs on channel 0 at steady occupancy 2 -> output order equals input order across pointer wrap, no spurious full/empty.
REQ-037 Reset mid-operation: 3 words queued on channel 0, drop_cnt=5, pull rst_n low between edges -> out_valid=0 and drop_cnt=0 before next edge; lock mask reads 0.
REQ-038 Parameter sweep: NCH=8, DATA_W=6, DEPTH=2 -> in_addr=7, in_data=6'b000111 yields channel 7 out_data=7'b1000111; third push while stalled sees in_ready=0.
